stq_cam_multi_l: RTL and testbench
==================================

Name: stq_cam_multi_L

Overview:
- Parametrised store-queue address CAM for the LSQ. It tracks DEPTH in-flight stores per row.
- Each entry holds addrEO, odd, byte mask and sub-bank mask, plus a 4-state lifecycle FSM.
- Replaces the fixed 2-write/6-check, 32-entry buffer array with configurable write, check and entry counts.
- Adds explicit states, exception flush, a free-entry count and protocol-error reporting.

Parameters:
ADDR_W, 36, addrEO width
DEPTH, 32, entries per row
NWRT, 2, write/update channels
NCHK, 6, load-check channels
BYTES_W, 4, byte-mask width
SUB_W, 8, sub-bank mask width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
excpt  in  1  pipeline flush
wrt_en  in  NWRT*DEPTH  per-channel one-hot entry allocate; channel c uses bits [c*DEPTH+:DEPTH]
wrt_addrEO  in  NWRT*ADDR_W  store address per channel
wrt_odd  in  NWRT  odd-bank flag per channel
wrt_bytes  in  NWRT*BYTES_W  byte mask per channel
wrt_subBNK  in  NWRT*SUB_W  sub-bank mask per channel
upd_en  in  NWRT*DEPTH  store data arrived, per channel one-hot
passe_en  in  DEPTH  store retired
free_en  in  DEPTH  store drained to cache
chk_en  in  NCHK  load check valid
chk_addrEO  in  NCHK*ADDR_W  load address
chk_odd  in  NCHK  load odd flag
chk_bytes  in  NCHK*BYTES_W  load byte mask
chk_subBNK  in  NCHK*SUB_W  load sub-bank mask
chk_match  out  NCHK*DEPTH  full forward possible
chk_partial  out  NCHK*DEPTH  overlap, no forward (load must wait)
free  out  DEPTH  entry in FREE
upd  out  DEPTH  entry in READY
passe  out  DEPTH  entry in PASSE
free_cnt  out  $clog2(DEPTH+1)  number of FREE entries, registered
err  out  1  registered one-cycle protocol-error pulse

Behaviour:
- Reset (async, any time, including mid-operation): all entries FREE, all fields 0; free all-ones; upd=0; passe=0; free_cnt=DEPTH; err=0.
- Entry states: FREE, ALLOC, READY, PASSE. Registered; visible one cycle after the causing input.
- Per-entry next state, highest priority first:
  - excpt: ALLOC/READY -> FREE. PASSE stays PASSE, because retired stores still drain.
  - free_en: PASSE -> FREE. free_en in any other state is ignored and sets err.
  - passe_en: READY -> PASSE. From ALLOC or FREE it is ignored and sets err.
  - Any upd_en channel: ALLOC -> READY. In other states it is ignored; no err.
  - wrt_en: FREE -> ALLOC and latch fields.
    - Write to a non-FREE entry: ignored, sets err.
    - Two channels hitting the same entry in one cycle: lowest channel wins, sets err.
- Field latches occur only on an accepted write.
- Same-cycle write and excpt: excpt wins, and the entry stays FREE.
- Check logic is combinational. It sees registered state only, with no bypass of same-cycle writes.
  - hit = chk_en && addrEO equal && odd equal && (chk_subBNK & subBNK) != 0 && state in {ALLOC, READY}.
  - chk_match = hit && state==READY && (chk_bytes & ~bytes)==0.
  - chk_partial = hit && !chk_match.
  - PASSE and FREE entries never hit.
- free_cnt = popcount of next-state FREE, registered. Range 0..DEPTH, no wrap.
- err = OR of all per-entry error conditions, registered; pulses for one cycle.

Decomposition:
- Package stq_l_pkg holds the state enum (FREE=0, ALLOC=1, READY=2, PASSE=3) and the default width constants.
- Sub-module stq_cam_multi_L_entry is one entry: FSM, field storage, NCHK comparators and a local err.
- The top module holds a generate loop over DEPTH, the write-channel priority encoder per entry, the popcount and the err OR-reduce.

Test Plan:
- Write on channel 0: entry 3 with addrEO=0x123456789, odd=0, bytes=4'b1111, subBNK=8'h01. Next cycle raise upd_en on channel 1 for entry 3. Then check channel 2 with the same address, bytes=4'b0011, subBNK=8'h01 -> chk_match[2*DEPTH+3]=1, partial=0.
- Same entry in ALLOC, check with bytes=4'b0001 -> partial=1, match=0. Entry READY with bytes=4'b0011, check bytes=4'b0100 -> partial=1. Check with subBNK=8'h02 -> both 0.
- Allocate entries 0..4, upd 0..2, passe 0 and 1, then excpt -> entries 2..4 FREE, entries 0 and 1 stay PASSE, free_cnt=DEPTH-2 next cycle.
- Channels 0 and 1 both write entry 7 in one cycle -> entry holds channel 0 fields, err=1 for exactly one cycle, free_cnt decrements by 1.
- Fill all DEPTH entries -> free_cnt=0. Further write to entry 5 -> ignored, err=1. Drain entry 5 through passe_en then free_en -> free_cnt=1.
- Assert rst asynchronously between clock edges with 10 entries allocated -> free all-ones and free_cnt=DEPTH immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/stq_l_pkg.sv
// Shared types and default widths for the store-queue address CAM.
package stq_l_pkg;

  // Lifecycle of one store-queue entry
  typedef enum logic [1:0] {
    ST_FREE  = 2'd0,
    ST_ALLOC = 2'd1,
    ST_READY = 2'd2,
    ST_PASSE = 2'd3
  } stq_state_e;

  localparam int unsigned STQ_ADDR_W  = 36;
  localparam int unsigned STQ_DEPTH   = 32;
  localparam int unsigned STQ_NWRT    = 2;
  localparam int unsigned STQ_NCHK    = 6;
  localparam int unsigned STQ_BYTES_W = 4;
  localparam int unsigned STQ_SUB_W   = 8;

endpackage

// File: rtl/stq_cam_multi_l_entry.sv
// One store-queue entry: lifecycle FSM, latched address fields and one
// comparator per load-check channel. Write arbitration happens in the top.
module stq_cam_multi_L_entry
  import stq_l_pkg::*;
#(
  parameter int ADDR_W  = STQ_ADDR_W,
  parameter int NCHK    = STQ_NCHK,
  parameter int BYTES_W = STQ_BYTES_W,
  parameter int SUB_W   = STQ_SUB_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    excpt,
  input  logic                    wrtReq,
  input  logic                    wrtMulti,
  input  logic [ADDR_W-1:0]       wrtAddrEO,
  input  logic                    wrtOdd,
  input  logic [BYTES_W-1:0]      wrtBytes,
  input  logic [SUB_W-1:0]        wrtSubBNK,
  input  logic                    updReq,
  input  logic                    passeReq,
  input  logic                    freeReq,
  input  logic [NCHK-1:0]         chkEn,
  input  logic [NCHK*ADDR_W-1:0]  chkAddrEO,
  input  logic [NCHK-1:0]         chkOdd,
  input  logic [NCHK*BYTES_W-1:0] chkBytes,
  input  logic [NCHK*SUB_W-1:0]   chkSubBNK,
  output logic [NCHK-1:0]         chkMatch,
  output logic [NCHK-1:0]         chkPartial,
  output stq_state_e              state,
  output logic                    nextFree,
  output logic                    err
);

  stq_state_e           state_q, state_d;
  logic [ADDR_W-1:0]    addrEO_q;
  logic                 odd_q;
  logic [BYTES_W-1:0]   bytes_q;
  logic [SUB_W-1:0]     subBNK_q;
  logic                 wrtAccept;

  // Fields are only captured when a write actually moves FREE to ALLOC
  assign wrtAccept = wrtReq && !excpt && (state_q == ST_FREE);

  // Next-state selection; a flush drops speculative stores but keeps retired ones draining
  always_comb begin
    state_d = state_q;
    if (excpt) begin
      if (state_q == ST_ALLOC || state_q == ST_READY) state_d = ST_FREE;
    end else begin
      case (state_q)
        ST_FREE:  if (wrtReq)   state_d = ST_ALLOC;
        ST_ALLOC: if (updReq)   state_d = ST_READY;
        ST_READY: if (passeReq) state_d = ST_PASSE;
        ST_PASSE: if (freeReq)  state_d = ST_FREE;
        default:                state_d = ST_FREE;
      endcase
    end
  end

  // Protocol violations seen by this entry; the top registers the OR of all entries
  always_comb begin
    err = 1'b0;
    if (freeReq && state_q != ST_PASSE) err = 1'b1;
    if (passeReq && (state_q == ST_ALLOC || state_q == ST_FREE)) err = 1'b1;
    if (wrtReq && state_q != ST_FREE) err = 1'b1;
    if (wrtMulti) err = 1'b1;
  end

  // State and field registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_FREE;
      addrEO_q <= '0;
      odd_q    <= 1'b0;
      bytes_q  <= '0;
      subBNK_q <= '0;
    end else begin
      state_q <= state_d;
      if (wrtAccept) begin
        addrEO_q <= wrtAddrEO;
        odd_q    <= wrtOdd;
        bytes_q  <= wrtBytes;
        subBNK_q <= wrtSubBNK;
      end
    end
  end

  // Load-check comparators against registered contents only (no same-cycle bypass)
  always_comb begin
    chkMatch   = '0;
    chkPartial = '0;
    for (int c = 0; c < NCHK; c++) begin
      logic hit;
      hit = chkEn[c]
         && (chkAddrEO[c*ADDR_W +: ADDR_W] == addrEO_q)
         && (chkOdd[c] == odd_q)
         && ((chkSubBNK[c*SUB_W +: SUB_W] & subBNK_q) != '0)
         && (state_q == ST_ALLOC || state_q == ST_READY);
      chkMatch[c]   = hit && (state_q == ST_READY)
                   && ((chkBytes[c*BYTES_W +: BYTES_W] & ~bytes_q) == '0);
      chkPartial[c] = hit && !chkMatch[c];
    end
  end

  assign state    = state_q;
  assign nextFree = (state_d == ST_FREE);

endmodule

// File: rtl/stq_cam_multi_l.sv
// Store-queue address CAM: DEPTH entries, NWRT write/update channels and
// NCHK load-check channels, with free-entry count and protocol-error pulse.
module stq_cam_multi_l
  import stq_l_pkg::*;
#(
  parameter int ADDR_W  = STQ_ADDR_W,
  parameter int DEPTH   = STQ_DEPTH,
  parameter int NWRT    = STQ_NWRT,
  parameter int NCHK    = STQ_NCHK,
  parameter int BYTES_W = STQ_BYTES_W,
  parameter int SUB_W   = STQ_SUB_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       excpt,
  input  logic [NWRT*DEPTH-1:0]      wrt_en,
  input  logic [NWRT*ADDR_W-1:0]     wrt_addrEO,
  input  logic [NWRT-1:0]            wrt_odd,
  input  logic [NWRT*BYTES_W-1:0]    wrt_bytes,
  input  logic [NWRT*SUB_W-1:0]      wrt_subBNK,
  input  logic [NWRT*DEPTH-1:0]      upd_en,
  input  logic [DEPTH-1:0]           passe_en,
  input  logic [DEPTH-1:0]           free_en,
  input  logic [NCHK-1:0]            chk_en,
  input  logic [NCHK*ADDR_W-1:0]     chk_addrEO,
  input  logic [NCHK-1:0]            chk_odd,
  input  logic [NCHK*BYTES_W-1:0]    chk_bytes,
  input  logic [NCHK*SUB_W-1:0]      chk_subBNK,
  output logic [NCHK*DEPTH-1:0]      chk_match,
  output logic [NCHK*DEPTH-1:0]      chk_partial,
  output logic [DEPTH-1:0]           free,
  output logic [DEPTH-1:0]           upd,
  output logic [DEPTH-1:0]           passe,
  output logic [$clog2(DEPTH+1)-1:0] free_cnt,
  output logic                       err
);

  localparam int CNT_W = $clog2(DEPTH+1);

  stq_state_e         entState [DEPTH];
  logic [DEPTH-1:0]   entNextFree;
  logic [DEPTH-1:0]   entErr;
  logic [CNT_W-1:0]   freeCnt_q, freeCnt_d;
  logic               err_q, err_d;

  for (genvar e = 0; e < DEPTH; e++) begin : g_entry
    logic [NWRT-1:0]    wrtHit;
    logic [NWRT-1:0]    updHit;
    logic               wrtMulti;
    logic [ADDR_W-1:0]  selAddrEO;
    logic               selOdd;
    logic [BYTES_W-1:0] selBytes;
    logic [SUB_W-1:0]   selSubBNK;
    logic [NCHK-1:0]    matchE;
    logic [NCHK-1:0]    partialE;

    for (genvar c = 0; c < NWRT; c++) begin : g_chan
      assign wrtHit[c] = wrt_en[c*DEPTH + e];
      assign updHit[c] = upd_en[c*DEPTH + e];
    end

    assign wrtMulti = (wrtHit & (wrtHit - NWRT'(1))) != '0;

    // Priority encoder: scanning downward leaves the lowest requesting channel selected
    always_comb begin
      selAddrEO = '0;
      selOdd    = 1'b0;
      selBytes  = '0;
      selSubBNK = '0;
      for (int c = NWRT-1; c >= 0; c--) begin
        if (wrtHit[c]) begin
          selAddrEO = wrt_addrEO[c*ADDR_W +: ADDR_W];
          selOdd    = wrt_odd[c];
          selBytes  = wrt_bytes[c*BYTES_W +: BYTES_W];
          selSubBNK = wrt_subBNK[c*SUB_W +: SUB_W];
        end
      end
    end

    stq_cam_multi_L_entry #(
      .ADDR_W  (ADDR_W),
      .NCHK    (NCHK),
      .BYTES_W (BYTES_W),
      .SUB_W   (SUB_W)
    ) u_entry (
      .clk        (clk),
      .rst        (rst),
      .excpt      (excpt),
      .wrtReq     (|wrtHit),
      .wrtMulti   (wrtMulti),
      .wrtAddrEO  (selAddrEO),
      .wrtOdd     (selOdd),
      .wrtBytes   (selBytes),
      .wrtSubBNK  (selSubBNK),
      .updReq     (|updHit),
      .passeReq   (passe_en[e]),
      .freeReq    (free_en[e]),
      .chkEn      (chk_en),
      .chkAddrEO  (chk_addrEO),
      .chkOdd     (chk_odd),
      .chkBytes   (chk_bytes),
      .chkSubBNK  (chk_subBNK),
      .chkMatch   (matchE),
      .chkPartial (partialE),
      .state      (entState[e]),
      .nextFree   (entNextFree[e]),
      .err        (entErr[e])
    );

    for (genvar c = 0; c < NCHK; c++) begin : g_chk
      assign chk_match[c*DEPTH + e]   = matchE[c];
      assign chk_partial[c*DEPTH + e] = partialE[c];
    end

    assign free[e]  = (entState[e] == ST_FREE);
    assign upd[e]   = (entState[e] == ST_READY);
    assign passe[e] = (entState[e] == ST_PASSE);
  end

  // Popcount of entries that will be FREE after this edge, and the error OR-reduce
  always_comb begin
    freeCnt_d = '0;
    for (int e = 0; e < DEPTH; e++) begin
      freeCnt_d = freeCnt_d + CNT_W'(entNextFree[e]);
    end
    err_d = |entErr;
  end

  // Registered count and single-cycle error pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      freeCnt_q <= CNT_W'(DEPTH);
      err_q     <= 1'b0;
    end else begin
      freeCnt_q <= freeCnt_d;
      err_q     <= err_d;
    end
  end

  assign free_cnt = freeCnt_q;
  assign err      = err_q;

endmodule

// File: tb/tb_stq_cam_multi_l.sv
// Directed testbench for the store-queue address CAM with hand-computed expectations.
module tb_stq_cam_multi_l;

  localparam int ADDR_W  = 36;
  localparam int DEPTH   = 32;
  localparam int NWRT    = 2;
  localparam int NCHK    = 6;
  localparam int BYTES_W = 4;
  localparam int SUB_W   = 8;
  localparam int CNT_W   = $clog2(DEPTH+1);

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    excpt;
  logic [NWRT*DEPTH-1:0]   wrt_en;
  logic [NWRT*ADDR_W-1:0]  wrt_addrEO;
  logic [NWRT-1:0]         wrt_odd;
  logic [NWRT*BYTES_W-1:0] wrt_bytes;
  logic [NWRT*SUB_W-1:0]   wrt_subBNK;
  logic [NWRT*DEPTH-1:0]   upd_en;
  logic [DEPTH-1:0]        passe_en;
  logic [DEPTH-1:0]        free_en;
  logic [NCHK-1:0]         chk_en;
  logic [NCHK*ADDR_W-1:0]  chk_addrEO;
  logic [NCHK-1:0]         chk_odd;
  logic [NCHK*BYTES_W-1:0] chk_bytes;
  logic [NCHK*SUB_W-1:0]   chk_subBNK;
  logic [NCHK*DEPTH-1:0]   chk_match;
  logic [NCHK*DEPTH-1:0]   chk_partial;
  logic [DEPTH-1:0]        free;
  logic [DEPTH-1:0]        upd;
  logic [DEPTH-1:0]        passe;
  logic [CNT_W-1:0]        free_cnt;
  logic                    err;

  int checkCnt = 0;
  int errCnt   = 0;

  stq_cam_multi_l dut (
    .clk         (clk),
    .rst         (rst),
    .excpt       (excpt),
    .wrt_en      (wrt_en),
    .wrt_addrEO  (wrt_addrEO),
    .wrt_odd     (wrt_odd),
    .wrt_bytes   (wrt_bytes),
    .wrt_subBNK  (wrt_subBNK),
    .upd_en      (upd_en),
    .passe_en    (passe_en),
    .free_en     (free_en),
    .chk_en      (chk_en),
    .chk_addrEO  (chk_addrEO),
    .chk_odd     (chk_odd),
    .chk_bytes   (chk_bytes),
    .chk_subBNK  (chk_subBNK),
    .chk_match   (chk_match),
    .chk_partial (chk_partial),
    .free        (free),
    .upd         (upd),
    .passe       (passe),
    .free_cnt    (free_cnt),
    .err         (err)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCnt++;
    if (actual !== expected) begin
      errCnt++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic clearControls();
    excpt      = 1'b0;
    wrt_en     = '0;
    wrt_addrEO = '0;
    wrt_odd    = '0;
    wrt_bytes  = '0;
    wrt_subBNK = '0;
    upd_en     = '0;
    passe_en   = '0;
    free_en    = '0;
  endtask

  task automatic clearChecks();
    chk_en     = '0;
    chk_addrEO = '0;
    chk_odd    = '0;
    chk_bytes  = '0;
    chk_subBNK = '0;
  endtask

  task automatic setWrite(input int ch, input int idx, input logic [ADDR_W-1:0] addr,
                          input logic odd, input logic [BYTES_W-1:0] bytes, input logic [SUB_W-1:0] sub);
    wrt_en[ch*DEPTH + idx]             = 1'b1;
    wrt_addrEO[ch*ADDR_W +: ADDR_W]    = addr;
    wrt_odd[ch]                        = odd;
    wrt_bytes[ch*BYTES_W +: BYTES_W]   = bytes;
    wrt_subBNK[ch*SUB_W +: SUB_W]      = sub;
  endtask

  task automatic setCheck(input int ch, input logic [ADDR_W-1:0] addr,
                          input logic odd, input logic [BYTES_W-1:0] bytes, input logic [SUB_W-1:0] sub);
    chk_en[ch]                         = 1'b1;
    chk_addrEO[ch*ADDR_W +: ADDR_W]    = addr;
    chk_odd[ch]                        = odd;
    chk_bytes[ch*BYTES_W +: BYTES_W]   = bytes;
    chk_subBNK[ch*SUB_W +: SUB_W]      = sub;
  endtask

  // One clock with the current inputs, then sample point 1 time unit after the edge
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    clearControls();
  endtask

  task automatic doReset();
    rst = 1'b1;
    clearControls();
    clearChecks();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clearControls();
    clearChecks();
    doReset();

    // Reset state
    checkOutput("rst_free",     64'(free),     64'hFFFF_FFFF);
    checkOutput("rst_upd",      64'(upd),      64'h0);
    checkOutput("rst_passe",    64'(passe),    64'h0);
    checkOutput("rst_free_cnt", 64'(free_cnt), 64'd32);
    checkOutput("rst_err",      64'(err),      64'h0);

    // Basic forwarding: entry 3 on ch0, entry 4 on ch1
    setWrite(0, 3, 36'h1_2345_6789, 1'b0, 4'b1111, 8'h01);
    setWrite(1, 4, 36'h0_ABCD_EF00, 1'b1, 4'b0011, 8'h10);
    applyStimulus();
    checkOutput("alloc_free",     64'(free),     64'hFFFF_FFE7);
    checkOutput("alloc_free_cnt", 64'(free_cnt), 64'd30);
    checkOutput("alloc_err",      64'(err),      64'h0);
    setCheck(2, 36'h1_2345_6789, 1'b0, 4'b0001, 8'h01);
    #1;
    checkOutput("alloc_partial", 64'(chk_partial[2*DEPTH+3]), 64'h1);
    checkOutput("alloc_match",   64'(chk_match[2*DEPTH+3]),   64'h0);
    clearChecks();
    upd_en[1*DEPTH + 3] = 1'b1;
    upd_en[0*DEPTH + 4] = 1'b1;
    applyStimulus();
    checkOutput("ready_upd", 64'(upd), 64'h18);
    setCheck(2, 36'h1_2345_6789, 1'b0, 4'b0011, 8'h01);
    #1;
    checkOutput("fwd_match",   64'(chk_match[2*DEPTH+3]),   64'h1);
    checkOutput("fwd_partial", 64'(chk_partial[2*DEPTH+3]), 64'h0);
    clearChecks();
    setCheck(2, 36'h1_2345_6789, 1'b0, 4'b0011, 8'h02);
    setCheck(5, 36'h0_ABCD_EF00, 1'b1, 4'b0100, 8'h10);
    setCheck(3, 36'h0_ABCD_EF00, 1'b0, 4'b0001, 8'h10);
    #1;
    checkOutput("sub_miss_match",   64'(chk_match[2*DEPTH+3]),   64'h0);
    checkOutput("sub_miss_partial", 64'(chk_partial[2*DEPTH+3]), 64'h0);
    checkOutput("bytes_partial",    64'(chk_partial[5*DEPTH+4]), 64'h1);
    checkOutput("bytes_match",      64'(chk_match[5*DEPTH+4]),   64'h0);
    checkOutput("odd_miss_partial", 64'(chk_partial[3*DEPTH+4]), 64'h0);
    clearChecks();

    // Exception flush keeps retired stores, drops the rest
    doReset();
    setWrite(0, 0, 36'h100, 1'b0, 4'hF, 8'h01);
    setWrite(1, 1, 36'h104, 1'b0, 4'hF, 8'h01);
    applyStimulus();
    setWrite(0, 2, 36'h108, 1'b0, 4'hF, 8'h01);
    setWrite(1, 3, 36'h10C, 1'b0, 4'hF, 8'h01);
    applyStimulus();
    setWrite(0, 4, 36'h110, 1'b0, 4'hF, 8'h01);
    applyStimulus();
    checkOutput("fl_alloc_cnt", 64'(free_cnt), 64'd27);
    upd_en[0*DEPTH + 0] = 1'b1;
    upd_en[1*DEPTH + 1] = 1'b1;
    applyStimulus();
    upd_en[0*DEPTH + 2] = 1'b1;
    applyStimulus();
    checkOutput("fl_upd", 64'(upd), 64'h7);
    passe_en = 32'h3;
    applyStimulus();
    checkOutput("fl_passe_pre", 64'(passe), 64'h3);
    checkOutput("fl_upd_pre",   64'(upd),   64'h4);
    excpt = 1'b1;
    setWrite(0, 10, 36'h200, 1'b0, 4'hF, 8'h01);
    applyStimulus();
    checkOutput("fl_free",     64'(free),     64'hFFFF_FFFC);
    checkOutput("fl_passe",    64'(passe),    64'h3);
    checkOutput("fl_upd",      64'(upd),      64'h0);
    checkOutput("fl_free_cnt", 64'(free_cnt), 64'd30);
    checkOutput("fl_err",      64'(err),      64'h0);

    // Two channels writing one entry: channel 0 wins, one-cycle err
    doReset();
    setWrite(0, 7, 36'hAAA, 1'b0, 4'hF, 8'h01);
    setWrite(1, 7, 36'hBBB, 1'b1, 4'h3, 8'h02);
    applyStimulus();
    checkOutput("col_err",      64'(err),      64'h1);
    checkOutput("col_free_cnt", 64'(free_cnt), 64'd31);
    checkOutput("col_free",     64'(free),     64'hFFFF_FF7F);
    setCheck(0, 36'hAAA, 1'b0, 4'h1, 8'h01);
    setCheck(1, 36'hBBB, 1'b1, 4'h1, 8'h02);
    #1;
    checkOutput("col_ch0_fields", 64'(chk_partial[0*DEPTH+7]), 64'h1);
    checkOutput("col_ch1_fields", 64'(chk_partial[1*DEPTH+7]), 64'h0);
    clearChecks();
    applyStimulus();
    checkOutput("col_err_pulse", 64'(err), 64'h0);

    // Fill every entry, then a write to a busy entry, then drain one entry
    doReset();
    for (int i = 0; i < DEPTH/2; i++) begin
      setWrite(0, 2*i,     36'(2*i),     1'b0, 4'hF, 8'h01);
      setWrite(1, 2*i + 1, 36'(2*i + 1), 1'b0, 4'hF, 8'h01);
      applyStimulus();
    end
    checkOutput("full_cnt",  64'(free_cnt), 64'd0);
    checkOutput("full_free", 64'(free),     64'h0);
    setWrite(0, 5, 36'hDEAD, 1'b0, 4'hF, 8'h01);
    applyStimulus();
    checkOutput("busy_wr_err", 64'(err),      64'h1);
    checkOutput("busy_wr_cnt", 64'(free_cnt), 64'd0);
    upd_en[0*DEPTH + 5] = 1'b1;
    applyStimulus();
    checkOutput("drain_upd",     64'(upd), 64'h20);
    checkOutput("drain_upd_err", 64'(err), 64'h0);
    passe_en[5] = 1'b1;
    applyStimulus();
    checkOutput("drain_passe", 64'(passe), 64'h20);
    free_en[5] = 1'b1;
    free_en[6] = 1'b1;
    applyStimulus();
    checkOutput("drain_cnt",     64'(free_cnt), 64'd1);
    checkOutput("drain_free",    64'(free),     64'h20);
    checkOutput("bad_free_err",  64'(err),      64'h1);

    // Asynchronous reset between edges with 10 entries allocated
    doReset();
    for (int i = 0; i < 5; i++) begin
      setWrite(0, 2*i,     36'h300, 1'b0, 4'hF, 8'h01);
      setWrite(1, 2*i + 1, 36'h304, 1'b0, 4'hF, 8'h01);
      applyStimulus();
    end
    checkOutput("pre_arst_cnt", 64'(free_cnt), 64'd22);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("arst_free", 64'(free),     64'hFFFF_FFFF);
    checkOutput("arst_cnt",  64'(free_cnt), 64'd32);
    checkOutput("arst_err",  64'(err),      64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errCnt, checkCnt);
    $finish;
  end

endmodule
